// File: rtl/apb3_timer_pkg.sv
// Shared definitions for the APB3 timer: register map, field layout and reset values.
package apb3_timer_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    // Word index of each register (PADDR[7:2]).
    localparam logic [5:0] IDX_CTRL = 6'd0;
    localparam logic [5:0] IDX_SR   = 6'd1;
    localparam logic [5:0] IDX_CNT  = 6'd2;
    localparam logic [5:0] IDX_PSC  = 6'd3;
    localparam logic [5:0] IDX_ARR  = 6'd4;
    localparam logic [5:0] IDX_CCR  = 6'd5;
    localparam logic [5:0] IDX_LAST = IDX_CCR;

    localparam int CTRL_CEN_BIT  = 0;
    localparam int CTRL_OPM_BIT  = 1;
    localparam int CTRL_DIR_BIT  = 2;
    localparam int CTRL_UIE_BIT  = 3;
    localparam int CTRL_CCIE_BIT = 4;
    localparam int SR_UIF_BIT    = 0;
    localparam int SR_CCIF_BIT   = 1;

    // Field order matches the bit positions above (LSB last).
    typedef struct packed {
        logic ccie;
        logic uie;
        logic dir;
        logic opm;
        logic cen;
    } ctrl_t;

    typedef struct packed {
        logic ccif;
        logic uif;
    } sr_t;

    localparam ctrl_t            CTRL_RST = '0;
    localparam sr_t              SR_RST   = '0;
    localparam logic [CNT_W-1:0] CNT_RST  = 16'h0000;
    localparam logic [CNT_W-1:0] PSC_RST  = 16'h0000;
    localparam logic [CNT_W-1:0] ARR_RST  = 16'hFFFF;
    localparam logic [CNT_W-1:0] CCR_RST  = 16'h0000;

    function automatic logic idx_mapped(input logic [5:0] idx);
        return idx <= IDX_LAST;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: counts enabled cycles and emits a one-cycle tick every PSC+1 of them.
module timer_prescaler
    import apb3_timer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] psc,
    input  logic             clear,
    output logic             tick
);

    logic [CNT_W-1:0] pc_q;
    logic [CNT_W-1:0] pc_d;

    assign tick = enable && (pc_q == psc);

    always_comb begin
        pc_d = pc_q;
        if (clear) begin
            pc_d = '0;
        end else if (enable) begin
            pc_d = tick ? '0 : pc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/apb3_timer.sv
// APB3 up/down timer with prescaler, auto-reload, compare/PWM output and level interrupt.
module apb3_timer
    import apb3_timer_pkg::*;
(
    input  logic              io_mainClk,
    input  logic              resetCtrl_systemReset,
    input  logic [ADDR_W-1:0] io_apb_PADDR,
    input  logic              io_apb_PSEL,
    input  logic              io_apb_PENABLE,
    input  logic              io_apb_PWRITE,
    input  logic [DATA_W-1:0] io_apb_PWDATA,
    output logic              io_apb_PREADY,
    output logic [DATA_W-1:0] io_apb_PRDATA,
    output logic              io_apb_PSLVERROR,
    output logic              io_pwm,
    output logic              io_interrupt
);

    ctrl_t            ctrl_q, ctrl_d;
    sr_t              sr_q,   sr_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [CNT_W-1:0] psc_q,  psc_d;
    logic [CNT_W-1:0] arr_q,  arr_d;
    logic [CNT_W-1:0] ccr_q,  ccr_d;

    logic [5:0]        reg_idx;
    logic              addr_ok;
    logic              wr_en;
    logic              wr_ctrl, wr_sr, wr_cnt, wr_psc, wr_arr, wr_ccr;
    logic              tick;
    logic [CNT_W-1:0]  cnt_hw;
    logic              uif_set;
    logic              ccif_set;
    logic [DATA_W-1:0] rd_data;
    logic              bus_unused;

    assign bus_unused = ^{io_apb_PADDR[ADDR_W-1:8], io_apb_PADDR[1:0], io_apb_PWDATA[DATA_W-1:CNT_W]};

    // APB handshake: PREADY is tied high, so every access completes in its first
    // access-phase cycle; a write commits on the edge with PSEL & PENABLE & PWRITE,
    // and unmapped offsets answer with PSLVERROR and leave all state untouched.
    assign reg_idx = io_apb_PADDR[7:2];
    assign addr_ok = idx_mapped(reg_idx);
    assign wr_en   = io_apb_PSEL && io_apb_PENABLE && io_apb_PWRITE && addr_ok;

    assign wr_ctrl = wr_en && (reg_idx == IDX_CTRL);
    assign wr_sr   = wr_en && (reg_idx == IDX_SR);
    assign wr_cnt  = wr_en && (reg_idx == IDX_CNT);
    assign wr_psc  = wr_en && (reg_idx == IDX_PSC);
    assign wr_arr  = wr_en && (reg_idx == IDX_ARR);
    assign wr_ccr  = wr_en && (reg_idx == IDX_CCR);

    timer_prescaler u_prescaler (
        .clk    (io_mainClk),
        .rst_n  (resetCtrl_systemReset),
        .enable (ctrl_q.cen),
        .psc    (psc_q),
        .clear  (wr_psc || wr_cnt),
        .tick   (tick)
    );

    always_comb begin
        cnt_hw  = cnt_q;
        uif_set = 1'b0;
        if (tick) begin
            if (!ctrl_q.dir) begin
                if (cnt_q == arr_q) begin
                    cnt_hw  = '0;
                    uif_set = 1'b1;
                end else begin
                    cnt_hw = cnt_q + 16'd1;
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_hw  = arr_q;
                    uif_set = 1'b1;
                end else begin
                    cnt_hw = cnt_q - 16'd1;
                end
            end
        end
        ccif_set = tick && (cnt_hw == ccr_q);
    end

    // Bus writes to CTRL/CNT override hardware; hardware flag sets override W1C.
    always_comb begin
        ctrl_d = ctrl_q;
        if (uif_set && ctrl_q.opm) begin
            ctrl_d.cen = 1'b0;
        end
        if (wr_ctrl) begin
            ctrl_d = ctrl_t'(io_apb_PWDATA[4:0]);
        end

        sr_d = sr_q;
        if (wr_sr) begin
            sr_d.uif  = sr_q.uif  & ~io_apb_PWDATA[SR_UIF_BIT];
            sr_d.ccif = sr_q.ccif & ~io_apb_PWDATA[SR_CCIF_BIT];
        end
        if (uif_set) begin
            sr_d.uif = 1'b1;
        end
        if (ccif_set) begin
            sr_d.ccif = 1'b1;
        end

        cnt_d = wr_cnt ? io_apb_PWDATA[CNT_W-1:0] : cnt_hw;
        psc_d = wr_psc ? io_apb_PWDATA[CNT_W-1:0] : psc_q;
        arr_d = wr_arr ? io_apb_PWDATA[CNT_W-1:0] : arr_q;
        ccr_d = wr_ccr ? io_apb_PWDATA[CNT_W-1:0] : ccr_q;
    end

    always_ff @(posedge io_mainClk or negedge resetCtrl_systemReset) begin
        if (!resetCtrl_systemReset) begin
            ctrl_q <= CTRL_RST;
            sr_q   <= SR_RST;
            cnt_q  <= CNT_RST;
            psc_q  <= PSC_RST;
            arr_q  <= ARR_RST;
            ccr_q  <= CCR_RST;
        end else begin
            ctrl_q <= ctrl_d;
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            psc_q  <= psc_d;
            arr_q  <= arr_d;
            ccr_q  <= ccr_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_idx)
            IDX_CTRL: rd_data = {27'd0, ctrl_q};
            IDX_SR:   rd_data = {30'd0, sr_q};
            IDX_CNT:  rd_data = {16'd0, cnt_q};
            IDX_PSC:  rd_data = {16'd0, psc_q};
            IDX_ARR:  rd_data = {16'd0, arr_q};
            IDX_CCR:  rd_data = {16'd0, ccr_q};
            default:  rd_data = '0;
        endcase
    end

    assign io_apb_PREADY    = 1'b1;
    assign io_apb_PRDATA    = (io_apb_PSEL && !io_apb_PWRITE && addr_ok) ? rd_data : '0;
    assign io_apb_PSLVERROR = io_apb_PSEL && !addr_ok;

    assign io_interrupt = (sr_q.uif && ctrl_q.uie) || (sr_q.ccif && ctrl_q.ccie);
    assign io_pwm       = cnt_q < ccr_q;

endmodule

// File: tb/tb_apb3_timer.sv
// Directed testbench for apb3_timer: APB driver tasks, expected-value queue and one summary line.
module tb_apb3_timer;

    localparam logic [19:0] A_CTRL = 20'h00;
    localparam logic [19:0] A_SR   = 20'h04;
    localparam logic [19:0] A_CNT  = 20'h08;
    localparam logic [19:0] A_PSC  = 20'h0C;
    localparam logic [19:0] A_ARR  = 20'h10;
    localparam logic [19:0] A_CCR  = 20'h14;

    logic        clk;
    logic        rst_n;
    logic [19:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        pwm;
    logic        irq;

    int checks;
    int errors;
    logic [31:0] exp_q[$];

    apb3_timer dut (
        .io_mainClk            (clk),
        .resetCtrl_systemReset (rst_n),
        .io_apb_PADDR          (paddr),
        .io_apb_PSEL           (psel),
        .io_apb_PENABLE        (penable),
        .io_apb_PWRITE         (pwrite),
        .io_apb_PWDATA         (pwdata),
        .io_apb_PREADY         (pready),
        .io_apb_PRDATA         (prdata),
        .io_apb_PSLVERROR      (pslverr),
        .io_pwm                (pwm),
        .io_interrupt          (irq)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
    endtask

    // Ends at a falling edge with reset released.
    task automatic do_reset();
        rst_n = 1'b0;
        bus_idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a falling edge; commits on the second rising edge, returns at the next falling edge.
    task automatic apb_write(input logic [19:0] addr, input logic [31:0] data);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = addr;
        pwdata  = data;
        @(posedge clk);
        @(negedge clk);
        penable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_idle();
    endtask

    task automatic apb_read(input logic [19:0] addr, output logic [31:0] data, output logic err);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = addr;
        @(posedge clk);
        @(negedge clk);
        penable = 1'b1;
        #1;
        data = prdata;
        err  = pslverr;
        @(posedge clk);
        @(negedge clk);
        bus_idle();
    endtask

    // Setup-phase-only read: combinational PRDATA, no clock edge consumed.
    task automatic apb_peek(input logic [19:0] addr, output logic [31:0] data, output logic err);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = addr;
        #1;
        data = prdata;
        err  = pslverr;
        bus_idle();
    endtask

    task automatic peek_check(input string tag, input logic [19:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_peek(addr, d, e);
        check_eq(tag, d, exp);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus_idle();

        #1;
        check_eq("reset_pready", {31'd0, pready}, 32'd1);
        check_eq("reset_pwm", {31'd0, pwm}, 32'd0);
        check_eq("reset_irq", {31'd0, irq}, 32'd0);
        do_reset();

        // Reset values and unmapped access
        apb_read(A_ARR, rd, err);
        check_eq("arr_reset_read", rd, 32'h0000FFFF);
        check_eq("arr_reset_err", {31'd0, err}, 32'd0);
        peek_check("ctrl_reset", A_CTRL, 32'd0);
        peek_check("sr_reset", A_SR, 32'd0);
        apb_read(20'h18, rd, err);
        check_eq("unmapped_rdata", rd, 32'd0);
        check_eq("unmapped_err", {31'd0, err}, 32'd1);
        apb_write(20'h20, 32'hFFFF_FFFF);
        apb_write(20'h18, 32'hFFFF_FFFF);
        peek_check("unmapped_ctrl", A_CTRL, 32'd0);
        peek_check("unmapped_cnt", A_CNT, 32'd0);
        peek_check("unmapped_psc", A_PSC, 32'd0);
        peek_check("unmapped_arr", A_ARR, 32'h0000FFFF);
        peek_check("unmapped_ccr", A_CCR, 32'd0);

        // Up-count with PSC=1, ARR=3
        do_reset();
        apb_write(A_PSC, 32'd1);
        apb_write(A_ARR, 32'd3);
        apb_write(A_CTRL, 32'h1);
        exp_q = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd2, 32'd2, 32'd3, 32'd3, 32'd0};
        peek_check("up_cnt", A_CNT, exp_q.pop_front());
        while (exp_q.size() > 0) begin
            @(negedge clk);
            peek_check("up_cnt", A_CNT, exp_q.pop_front());
        end
        peek_check("up_sr_wrap", A_SR, 32'h3);
        check_eq("up_irq_masked", {31'd0, irq}, 32'd0);
        apb_write(A_CTRL, 32'h08);
        check_eq("up_irq_uie", {31'd0, irq}, 32'd1);
        repeat (3) @(negedge clk);
        peek_check("up_cnt_stopped", A_CNT, 32'd1);
        apb_write(A_SR, 32'h1);
        peek_check("up_sr_w1c", A_SR, 32'h2);
        check_eq("up_irq_cleared", {31'd0, irq}, 32'd0);
        apb_write(A_CTRL, 32'h10);
        check_eq("up_irq_ccie", {31'd0, irq}, 32'd1);

        // Down-count from 2 with ARR=5, PSC=0
        do_reset();
        apb_write(A_ARR, 32'd5);
        apb_write(A_CNT, 32'd2);
        apb_write(A_CTRL, 32'h5);
        peek_check("dn_cnt0", A_CNT, 32'd2);
        @(negedge clk);
        peek_check("dn_cnt1", A_CNT, 32'd1);
        peek_check("dn_sr1", A_SR, 32'h0);
        @(negedge clk);
        peek_check("dn_cnt2", A_CNT, 32'd0);
        peek_check("dn_sr2", A_SR, 32'h2);
        @(negedge clk);
        peek_check("dn_cnt3", A_CNT, 32'd5);
        peek_check("dn_sr3", A_SR, 32'h3);

        // One-pulse mode, ARR=2
        do_reset();
        apb_write(A_ARR, 32'd2);
        apb_write(A_CTRL, 32'h3);
        repeat (6) @(negedge clk);
        peek_check("opm_ctrl", A_CTRL, 32'h2);
        peek_check("opm_cnt", A_CNT, 32'd0);
        peek_check("opm_sr", A_SR, 32'h3);

        // W1C colliding with a UIF set
        do_reset();
        apb_write(A_ARR, 32'd2);
        apb_write(A_CTRL, 32'h1);
        @(negedge clk);
        apb_write(A_SR, 32'h1);
        peek_check("w1c_collide", A_SR, 32'h3);
        apb_write(A_SR, 32'h1);
        peek_check("w1c_later", A_SR, 32'h2);

        // PWM and compare flag, CCR=2, ARR=3
        do_reset();
        apb_write(A_CCR, 32'd2);
        apb_write(A_ARR, 32'd3);
        apb_write(A_CTRL, 32'h1);
        exp_q = '{32'd1, 32'd1, 32'd0, 32'd0, 32'd1};
        check_eq("pwm0", {31'd0, pwm}, exp_q.pop_front());
        @(negedge clk);
        check_eq("pwm1", {31'd0, pwm}, exp_q.pop_front());
        peek_check("pwm_sr1", A_SR, 32'h0);
        @(negedge clk);
        check_eq("pwm2", {31'd0, pwm}, exp_q.pop_front());
        peek_check("pwm_sr2", A_SR, 32'h2);
        @(negedge clk);
        check_eq("pwm3", {31'd0, pwm}, exp_q.pop_front());
        @(negedge clk);
        check_eq("pwm4", {31'd0, pwm}, exp_q.pop_front());
        peek_check("pwm_sr4", A_SR, 32'h3);

        // Reset asserted mid-transfer
        do_reset();
        apb_write(A_CCR, 32'd5);
        check_eq("mid_pwm_before", {31'd0, pwm}, 32'd1);
        psel    = 1'b1;
        pwrite  = 1'b1;
        paddr   = A_CTRL;
        pwdata  = 32'h1;
        @(posedge clk);
        @(negedge clk);
        penable = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_pwm", {31'd0, pwm}, 32'd0);
        check_eq("mid_irq", {31'd0, irq}, 32'd0);
        check_eq("mid_pready", {31'd0, pready}, 32'd1);
        @(negedge clk);
        bus_idle();
        @(negedge clk);
        rst_n = 1'b1;
        peek_check("mid_ctrl", A_CTRL, 32'd0);
        peek_check("mid_ccr", A_CCR, 32'd0);
        apb_write(A_PSC, 32'd7);
        peek_check("mid_psc_after", A_PSC, 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
